// File: rtl/alarm_controller.sv
// Alarm buzzer sequencer: compares a programmable 4-digit value against the live
// digits and runs the arm/ring/snooze/timeout machine with a pulsed beep output.
module alarm_controller #(
  parameter int unsigned BEEP_ON      = 25_000_000,
  parameter int unsigned BEEP_OFF     = 25_000_000,
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned SNOOZE_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic [3:0]  d0_i,
  input  logic [3:0]  d1_i,
  input  logic [3:0]  d2_i,
  input  logic [3:0]  d3_i,
  input  logic        set_en_i,
  input  logic [15:0] set_val_i,
  input  logic        arm_i,
  input  logic        disarm_i,
  input  logic        ack_i,
  input  logic        snooze_i,
  output logic        buzzer_o,
  output logic [1:0]  state_o,
  output logic        missed_o,
  output logic [15:0] alarm_val_o
);

  localparam int unsigned BEEP_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int unsigned BEEP_W   = $clog2(BEEP_MAX + 1);
  localparam int unsigned RING_W   = $clog2(RING_TIMEOUT + 1);
  localparam int unsigned SNZ_W    = $clog2(SNOOZE_TICKS + 1);

  localparam logic [BEEP_W-1:0] ON_LAST   = BEEP_W'(BEEP_ON - 1);
  localparam logic [BEEP_W-1:0] OFF_LAST  = BEEP_W'(BEEP_OFF - 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_TICKS - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               buzzer_q, buzzer_d;
  logic               missed_q, missed_d;
  logic [15:0]        alarmVal_q, alarmVal_d;
  logic               match_q;
  logic               phaseOn_q, phaseOn_d;
  logic [BEEP_W-1:0]  beepCnt_q, beepCnt_d;
  logic [RING_W-1:0]  ringCnt_q, ringCnt_d;
  logic [SNZ_W-1:0]   snzCnt_q, snzCnt_d;

  logic               hit;
  logic               trigger;
  logic               enterRing;

  // Only a rising edge of equality triggers, so an ack while the digits still
  // match cannot immediately re-ring.
  assign hit     = ({d3_i, d2_i, d1_i, d0_i} == alarmVal_q);
  assign trigger = hit && !match_q;

  always_comb begin
    state_d    = state_q;
    alarmVal_d = alarmVal_q;
    buzzer_d   = 1'b0;
    missed_d   = 1'b0;
    phaseOn_d  = phaseOn_q;
    beepCnt_d  = beepCnt_q;
    ringCnt_d  = ringCnt_q;
    snzCnt_d   = snzCnt_q;
    enterRing  = 1'b0;

    if (disarm_i) begin
      state_d = DISARMED;
    end else if (set_en_i) begin
      alarmVal_d = set_val_i;
      if (state_q == RINGING || state_q == SNOOZE) state_d = ARMED;
    end else begin
      unique case (state_q)
        DISARMED: if (arm_i) state_d = ARMED;
        ARMED:    if (trigger) enterRing = 1'b1;
        RINGING: begin
          if (ack_i) begin
            state_d = ARMED;
          end else if (snooze_i) begin
            state_d  = SNOOZE;
            snzCnt_d = '0;
          end else if (tick_i && ringCnt_q == RING_LAST) begin
            state_d  = ARMED;
            missed_d = 1'b1;
          end else begin
            if (tick_i) ringCnt_d = ringCnt_q + RING_W'(1);
            // Each phase counter restarts at zero when the phase flips.
            if (phaseOn_q) begin
              if (beepCnt_q == ON_LAST) begin
                phaseOn_d = 1'b0;
                beepCnt_d = '0;
                buzzer_d  = 1'b0;
              end else begin
                beepCnt_d = beepCnt_q + BEEP_W'(1);
                buzzer_d  = 1'b1;
              end
            end else begin
              if (beepCnt_q == OFF_LAST) begin
                phaseOn_d = 1'b1;
                beepCnt_d = '0;
                buzzer_d  = 1'b1;
              end else begin
                beepCnt_d = beepCnt_q + BEEP_W'(1);
                buzzer_d  = 1'b0;
              end
            end
          end
        end
        SNOOZE: begin
          if (ack_i) begin
            state_d = ARMED;
          end else if (tick_i && snzCnt_q == SNZ_LAST) begin
            enterRing = 1'b1;
          end else if (tick_i) begin
            snzCnt_d = snzCnt_q + SNZ_W'(1);
          end
        end
        default: state_d = DISARMED;
      endcase
    end

    if (enterRing) begin
      state_d   = RINGING;
      phaseOn_d = 1'b1;
      beepCnt_d = '0;
      ringCnt_d = '0;
      buzzer_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DISARMED;
      buzzer_q   <= 1'b0;
      missed_q   <= 1'b0;
      alarmVal_q <= 16'h0000;
      match_q    <= 1'b0;
      phaseOn_q  <= 1'b0;
      beepCnt_q  <= '0;
      ringCnt_q  <= '0;
      snzCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      buzzer_q   <= buzzer_d;
      missed_q   <= missed_d;
      alarmVal_q <= alarmVal_d;
      match_q    <= hit;
      phaseOn_q  <= phaseOn_d;
      beepCnt_q  <= beepCnt_d;
      ringCnt_q  <= ringCnt_d;
      snzCnt_q   <= snzCnt_d;
    end
  end

  assign buzzer_o    = buzzer_q;
  assign state_o     = state_q;
  assign missed_o    = missed_q;
  assign alarm_val_o = alarmVal_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random traffic, checked
// against a cycle-level model built from elapsed-time arithmetic.
module tb_alarm_controller;

  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int RT  = 3;
  localparam int ST  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, setEn, arm, disarm, ack, snooze;
  logic [15:0] setVal;
  logic [15:0] digits;
  logic        buzzer, missed;
  logic [1:0]  state;
  logic [15:0] alarmVal;

  int checks = 0;
  int errors = 0;

  int          mState, mSince, mRingTicks, mSnzTicks;
  logic [15:0] mAlarm;
  logic        mMatch, mBuzzer, mMissed;

  always #5 clk = ~clk;

  alarm_controller #(
    .BEEP_ON(ON), .BEEP_OFF(OFF), .RING_TIMEOUT(RT), .SNOOZE_TICKS(ST)
  ) dut (
    .clk(clk), .rst(rst), .tick_i(tick),
    .d0_i(digits[3:0]), .d1_i(digits[7:4]), .d2_i(digits[11:8]), .d3_i(digits[15:12]),
    .set_en_i(setEn), .set_val_i(setVal), .arm_i(arm), .disarm_i(disarm),
    .ack_i(ack), .snooze_i(snooze),
    .buzzer_o(buzzer), .state_o(state), .missed_o(missed), .alarm_val_o(alarmVal)
  );

  task automatic modelReset();
    mState = 0; mAlarm = 16'h0000; mMatch = 1'b0; mBuzzer = 1'b0; mMissed = 1'b0;
    mSince = 0; mRingTicks = 0; mSnzTicks = 0;
  endtask

  // Buzzer is derived from cycles elapsed since the ring began, modulo the period.
  task automatic modelStep();
    logic hit, trig, enter;
    int   ns;
    hit = (digits == mAlarm);
    trig = hit && !mMatch;
    ns = mState;
    enter = 1'b0;
    mMissed = 1'b0;
    if (disarm) ns = 0;
    else if (setEn) begin
      mAlarm = setVal;
      if (mState >= 2) ns = 1;
    end else begin
      case (mState)
        0: if (arm) ns = 1;
        1: if (trig) enter = 1'b1;
        2: begin
          if (ack) ns = 1;
          else if (snooze) begin ns = 3; mSnzTicks = 0; end
          else if (tick && (mRingTicks + 1 == RT)) begin ns = 1; mMissed = 1'b1; end
          else begin
            mSince++;
            if (tick) mRingTicks++;
          end
        end
        default: begin
          if (ack) ns = 1;
          else if (tick) begin
            mSnzTicks++;
            if (mSnzTicks == ST) enter = 1'b1;
          end
        end
      endcase
    end
    if (enter) begin ns = 2; mSince = 0; mRingTicks = 0; end
    mState = ns;
    mBuzzer = (ns == 2) && ((mSince % (ON + OFF)) < ON);
    mMatch = hit;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] expState;
    expState = mState[1:0];
    checks++;
    assert (state === expState) else begin
      errors++; $error("FAIL %s state obs=%0d exp=%0d", tag, state, expState);
    end
    checks++;
    assert (buzzer === mBuzzer) else begin
      errors++; $error("FAIL %s buzzer obs=%0b exp=%0b", tag, buzzer, mBuzzer);
    end
    checks++;
    assert (missed === mMissed) else begin
      errors++; $error("FAIL %s missed obs=%0b exp=%0b", tag, missed, mMissed);
    end
    checks++;
    assert (alarmVal === mAlarm) else begin
      errors++; $error("FAIL %s alarm_val obs=%h exp=%h", tag, alarmVal, mAlarm);
    end
  endtask

  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int r, p;
    rst = 1'b1; tick = 0; setEn = 0; arm = 0; disarm = 0; ack = 0; snooze = 0;
    setVal = 16'h0000; digits = 16'h0000;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;

    // Basic ring and beep pattern
    setEn = 1; setVal = 16'h0010; applyStimulus("set"); setEn = 0;
    arm = 1; applyStimulus("arm"); arm = 0;
    digits = 16'h0009; applyStimulus("d0009");
    digits = 16'h0010; applyStimulus("trigger");
    repeat (10) applyStimulus("beep");

    // Ack while digits stay equal, then a fresh rising edge
    ack = 1; applyStimulus("ack"); ack = 0;
    repeat (10) applyStimulus("noRetrig");
    digits = 16'h0011; applyStimulus("d0011");
    digits = 16'h0010; applyStimulus("retrigger");
    repeat (2) applyStimulus("ring2");

    // Snooze then expiry after two ticks
    snooze = 1; applyStimulus("snooze"); snooze = 0;
    for (int i = 0; i < ST; i++) begin
      tick = 1; applyStimulus("snzTick"); tick = 0;
      applyStimulus("snzIdle");
    end
    repeat (5) applyStimulus("reRing");

    // Timeout after three unanswered ticks
    for (int i = 0; i < RT; i++) begin
      tick = 1; applyStimulus("ringTick"); tick = 0;
      applyStimulus("missedClear");
    end

    // Priority, disarmed trigger, set_en during snooze
    digits = 16'h0011; applyStimulus("pre");
    digits = 16'h0010; applyStimulus("ring3");
    disarm = 1; ack = 1; applyStimulus("disarmAck"); disarm = 0; ack = 0;
    digits = 16'h0011; applyStimulus("dis1");
    digits = 16'h0010; applyStimulus("disTrig");
    arm = 1; applyStimulus("rearm"); arm = 0;
    digits = 16'h0011; applyStimulus("pre2");
    digits = 16'h0010; applyStimulus("ring4");
    snooze = 1; applyStimulus("snooze2"); snooze = 0;
    setEn = 1; setVal = 16'h1234; applyStimulus("setInSnooze"); setEn = 0;

    // Asynchronous reset in the middle of an ON phase
    digits = 16'h1234; applyStimulus("ring5");
    repeat (2) applyStimulus("onPhase");
    #3 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReset");
    #1 rst = 1'b0;

    // Random traffic
    setEn = 1; setVal = 16'h0420; applyStimulus("randSet"); setEn = 0;
    arm = 1; applyStimulus("randArm"); arm = 0;
    for (int i = 0; i < 600; i++) begin
      setEn = 0; arm = 0; disarm = 0; ack = 0; snooze = 0;
      r = $urandom_range(0, 99);
      if (r < 2) disarm = 1;
      else if (r < 5) begin setEn = 1; setVal = 16'($urandom_range(0, 65535)); end
      else if (r < 9) ack = 1;
      else if (r < 13) snooze = 1;
      else if (r < 18) arm = 1;
      tick = ($urandom_range(0, 2) == 0);
      p = $urandom_range(0, 3);
      if (p < 2) digits = mAlarm;
      else if (p == 2) digits = mAlarm + 16'd1;
      else digits = 16'($urandom_range(0, 65535));
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
